letc_core_stage_e1: RTL and testbench
=====================================

Name: letc_core_stage_e1

Overview:
First execute stage of the LETC RV32 in-order core pipeline, sitting between Decode (D) and Execute-2 (E2).
- Computes integer ALU results, resolves branches and jumps, and generates load/store addresses.
- Issues the data-TLB lookup request for memory operations.
- Registers everything into the E1→E2 pipeline register under pipeline hazard control (stall, flush, ready).

Parameters:
None. Data and address widths are fixed at 32 bits; the VPN is 20 bits.

Ports:
i_clk  in  1  core clock; all state updates on the rising edge
i_rst_n  in  1  reset; synchronous, active-low
i_d_valid  in  1  D→E1 instruction valid
i_d_pc  in  32  instruction PC
i_d_rs1_val  in  32  rs1 operand value
i_d_rs2_val  in  32  rs2 operand value (also store data)
i_d_imm  in  32  sign-extended immediate
i_d_op1_sel  in  1  0 = rs1, 1 = PC
i_d_op2_sel  in  1  0 = rs2, 1 = imm
i_d_alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS2; 11-15 treated as ADD
i_d_br_type  in  2  0 none, 1 conditional branch, 2 JAL, 3 JALR
i_d_br_cond  in  3  RISC-V funct3: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU; 2/3 never taken
i_d_mem_op  in  2  0 none, 1 load, 2 store, 3 reserved (treated as none)
i_d_mem_size  in  2  0 byte, 1 half, 2 word
i_d_mem_signed  in  1  sign-extend a load
i_d_rd_idx  in  5  destination register index
i_d_rd_we  in  1  destination write enable
o_dtlb_req_valid  out  1  DTLB lookup request
o_dtlb_req_vpn  out  20  effective address [31:12]
i_dtlb_req_ready  in  1  DTLB accepts the request this cycle
o_e2_valid  out  1  E1→E2 valid
o_e2_pc  out  32  registered PC
o_e2_result  out  32  ALU result, or PC+4 for JAL/JALR
o_e2_mem_addr  out  32  effective address rs1+imm
o_e2_store_data  out  32  rs2 value
o_e2_mem_op  out  2  registered mem_op
o_e2_mem_size  out  2  registered mem_size
o_e2_mem_signed  out  1  registered mem_signed
o_e2_rd_idx  out  5  registered rd_idx
o_e2_rd_we  out  1  registered rd_we
o_e2_br_taken  out  1  redirect required
o_e2_br_target  out  32  redirect target
o_stage_ready  out  1  E1 can accept the current D instruction
i_stage_flush  in  1  kill contents
i_stage_stall  in  1  hold contents
o_debug  out  8  debug bus

Behaviour:
- Reset (i_rst_n=0 at a posedge): every o_e2_* register clears to 0 (valid, taken and rd_we all 0).
- Combinational datapath:
  - op1 = op1_sel ? pc : rs1; op2 = op2_sel ? imm : rs2.
  - Shifts use op2[4:0]. SRA is arithmetic. SLT is signed; SLTU is unsigned. SLT/SLTU results are 0 or 1.
  - Effective address ea = rs1 + imm (mod 2^32).
  - Branch condition compares rs1 vs rs2.
  - Conditional branch target = pc + imm; JAL target = pc + imm; JALR target = (rs1 + imm) & ~1.
  - taken = JAL | JALR | (branch & cond).
- DTLB request:
  - o_dtlb_req_valid = i_d_valid & (mem_op is 1 or 2) & ~i_stage_stall & ~i_stage_flush.
  - o_dtlb_req_vpn = ea[31:12]; it is driven unconditionally.
- o_stage_ready = ~i_stage_stall & ~(o_dtlb_req_valid & ~i_dtlb_req_ready).
- Pipeline register update at each posedge, in priority order:
  1. Reset.
  2. Flush: o_e2_valid ← 0 and o_e2_br_taken ← 0; other fields don't-care. Flush wins over stall.
  3. Stall: all o_e2_* hold.
  4. Otherwise, if o_stage_ready: capture all computed fields, with o_e2_valid ← i_d_valid and o_e2_br_taken ← i_d_valid & taken.
  5. Otherwise (TLB back-pressure): insert a bubble (o_e2_valid ← 0, o_e2_br_taken ← 0). D must hold its instruction.
- Invalid inputs (i_d_valid=0) never raise the DTLB request, br_taken or rd_we effects downstream, because valid gates them.
- Latency: 1 cycle from D input to o_e2_*.
- Misaligned addresses are passed through unchecked; E2 handles them.

Optional Feature:
LETC_CORE_E1_DEBUG_EN:
- Defined: o_debug is an 8-bit counter, synchronously reset to 0, incremented (wrapping 255→0) on each posedge where a valid instruction is captured into E2.
- Undefined: o_debug is tied to 8'h00 and no counter logic exists.

Test Plan:
- Reset: hold i_rst_n=0 for 2 clocks → o_e2_valid=0, o_e2_br_taken=0, o_debug=0; release, idle (i_d_valid=0) 2 clocks → outputs stay 0.
- ALU: ADD rs1=5, rs2=7 → result 12; SUB 3-5 → 0xFFFFFFFE; SRA 0x80000000 by 4 → 0xF8000000; SLTU 1 vs 0xFFFFFFFF → 1, all one cycle later with o_e2_valid=1.
- Branch: BLT rs1=-1, rs2=1, pc=0x100, imm=0x20 → taken=1, target 0x120; JALR rs1=0x203, imm=0 → target 0x202, result pc+4.
- Load with i_dtlb_req_ready=0: rs1=0x12345000, imm=0x10 → o_dtlb_req_valid=1, vpn 0x12345, o_stage_ready=0, next cycle o_e2_valid=0; ready=1 → captured with mem_addr 0x12345010.
- Stall then flush: capture ADD, assert stall 3 cycles → o_e2_* unchanged; assert flush with stall → o_e2_valid=0 next cycle.
- With LETC_CORE_E1_DEBUG_EN: 3 valid captures → o_debug=3; without the macro → o_debug=0 throughout.

Source files
------------

// File: rtl/letc_core_stage_e1_if.sv
// D->E1 instruction bus, DTLB request channel, E1->E2 pipeline register and
// hazard control for the LETC E1 stage. The stage connects through the slave
// modport; the upstream/downstream side uses master.
interface letc_core_stage_e1_if;
    // D -> E1 instruction
    logic        i_d_valid;
    logic [31:0] i_d_pc;
    logic [31:0] i_d_rs1_val;
    logic [31:0] i_d_rs2_val;
    logic [31:0] i_d_imm;
    logic        i_d_op1_sel;
    logic        i_d_op2_sel;
    logic [3:0]  i_d_alu_op;
    logic [1:0]  i_d_br_type;
    logic [2:0]  i_d_br_cond;
    logic [1:0]  i_d_mem_op;
    logic [1:0]  i_d_mem_size;
    logic        i_d_mem_signed;
    logic [4:0]  i_d_rd_idx;
    logic        i_d_rd_we;
    // DTLB lookup request
    logic        o_dtlb_req_valid;
    logic [19:0] o_dtlb_req_vpn;
    logic        i_dtlb_req_ready;
    // E1 -> E2 pipeline register
    logic        o_e2_valid;
    logic [31:0] o_e2_pc;
    logic [31:0] o_e2_result;
    logic [31:0] o_e2_mem_addr;
    logic [31:0] o_e2_store_data;
    logic [1:0]  o_e2_mem_op;
    logic [1:0]  o_e2_mem_size;
    logic        o_e2_mem_signed;
    logic [4:0]  o_e2_rd_idx;
    logic        o_e2_rd_we;
    logic        o_e2_br_taken;
    logic [31:0] o_e2_br_target;
    // hazard control
    logic        o_stage_ready;
    logic        i_stage_flush;
    logic        i_stage_stall;

    modport master (
        output i_d_valid, i_d_pc, i_d_rs1_val, i_d_rs2_val, i_d_imm,
               i_d_op1_sel, i_d_op2_sel, i_d_alu_op, i_d_br_type, i_d_br_cond,
               i_d_mem_op, i_d_mem_size, i_d_mem_signed, i_d_rd_idx, i_d_rd_we,
               i_dtlb_req_ready, i_stage_flush, i_stage_stall,
        input  o_dtlb_req_valid, o_dtlb_req_vpn,
               o_e2_valid, o_e2_pc, o_e2_result, o_e2_mem_addr, o_e2_store_data,
               o_e2_mem_op, o_e2_mem_size, o_e2_mem_signed, o_e2_rd_idx,
               o_e2_rd_we, o_e2_br_taken, o_e2_br_target, o_stage_ready
    );

    modport slave (
        input  i_d_valid, i_d_pc, i_d_rs1_val, i_d_rs2_val, i_d_imm,
               i_d_op1_sel, i_d_op2_sel, i_d_alu_op, i_d_br_type, i_d_br_cond,
               i_d_mem_op, i_d_mem_size, i_d_mem_signed, i_d_rd_idx, i_d_rd_we,
               i_dtlb_req_ready, i_stage_flush, i_stage_stall,
        output o_dtlb_req_valid, o_dtlb_req_vpn,
               o_e2_valid, o_e2_pc, o_e2_result, o_e2_mem_addr, o_e2_store_data,
               o_e2_mem_op, o_e2_mem_size, o_e2_mem_signed, o_e2_rd_idx,
               o_e2_rd_we, o_e2_br_taken, o_e2_br_target, o_stage_ready
    );
endinterface

// File: rtl/letc_core_stage_e1.sv
// LETC RV32 first execute stage: ALU, branch resolution, effective address,
// DTLB request and the E1->E2 pipeline register.
// Optional: define LETC_CORE_E1_DEBUG_EN to make o_debug a count of valid
// instructions captured into E2 (otherwise o_debug is tied to zero).
module letc_core_stage_e1 (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    letc_core_stage_e1_if.slave  bus,
    output logic [7:0]           o_debug
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned VPN_W = 20;

    logic [XLEN-1:0] op1, op2, alu_res, ea, pc_imm, pc_plus4;
    logic [XLEN-1:0] result, br_target;
    logic [4:0]      shamt;
    logic            cond_met, taken, is_jump, is_mem;
    logic            cmp_eq, cmp_lt, cmp_ltu;
    logic            tlb_req, stage_ready;

    // Operand selection and ALU
    always_comb begin
        op1     = bus.i_d_op1_sel ? bus.i_d_pc  : bus.i_d_rs1_val;
        op2     = bus.i_d_op2_sel ? bus.i_d_imm : bus.i_d_rs2_val;
        shamt   = op2[4:0];
        alu_res = op1 + op2;
        case (bus.i_d_alu_op)
            4'd1:    alu_res = op1 - op2;
            4'd2:    alu_res = op1 << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            4'd5:    alu_res = op1 ^ op2;
            4'd6:    alu_res = op1 >> shamt;
            4'd7:    alu_res = XLEN'($signed(op1) >>> shamt);
            4'd8:    alu_res = op1 | op2;
            4'd9:    alu_res = op1 & op2;
            4'd10:   alu_res = op2;
            default: alu_res = op1 + op2;
        endcase
    end

    // Branch condition, redirect target and final result
    always_comb begin
        cmp_eq   = bus.i_d_rs1_val == bus.i_d_rs2_val;
        cmp_lt   = $signed(bus.i_d_rs1_val) < $signed(bus.i_d_rs2_val);
        cmp_ltu  = bus.i_d_rs1_val < bus.i_d_rs2_val;
        case (bus.i_d_br_cond)
            3'd0:    cond_met = cmp_eq;
            3'd1:    cond_met = ~cmp_eq;
            3'd4:    cond_met = cmp_lt;
            3'd5:    cond_met = ~cmp_lt;
            3'd6:    cond_met = cmp_ltu;
            3'd7:    cond_met = ~cmp_ltu;
            default: cond_met = 1'b0;
        endcase
        ea        = bus.i_d_rs1_val + bus.i_d_imm;
        pc_imm    = bus.i_d_pc + bus.i_d_imm;
        pc_plus4  = bus.i_d_pc + XLEN'(4);
        is_jump   = (bus.i_d_br_type == 2'd2) || (bus.i_d_br_type == 2'd3);
        taken     = is_jump || ((bus.i_d_br_type == 2'd1) && cond_met);
        br_target = (bus.i_d_br_type == 2'd3) ? (ea & ~XLEN'(1)) : pc_imm;
        result    = is_jump ? pc_plus4 : alu_res;
    end

    // DTLB request and back-pressure towards D
    always_comb begin
        is_mem      = (bus.i_d_mem_op == 2'd1) || (bus.i_d_mem_op == 2'd2);
        tlb_req     = bus.i_d_valid & is_mem & ~bus.i_stage_stall & ~bus.i_stage_flush;
        stage_ready = ~bus.i_stage_stall & ~(tlb_req & ~bus.i_dtlb_req_ready);
    end

    assign bus.o_dtlb_req_valid = tlb_req;
    assign bus.o_dtlb_req_vpn   = ea[XLEN-1 -: VPN_W];
    assign bus.o_stage_ready    = stage_ready;

    // E1->E2 pipeline register: reset > flush > stall > capture > bubble
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_e2_valid      <= 1'b0;
            bus.o_e2_pc         <= '0;
            bus.o_e2_result     <= '0;
            bus.o_e2_mem_addr   <= '0;
            bus.o_e2_store_data <= '0;
            bus.o_e2_mem_op     <= '0;
            bus.o_e2_mem_size   <= '0;
            bus.o_e2_mem_signed <= 1'b0;
            bus.o_e2_rd_idx     <= '0;
            bus.o_e2_rd_we      <= 1'b0;
            bus.o_e2_br_taken   <= 1'b0;
            bus.o_e2_br_target  <= '0;
        end else if (bus.i_stage_flush) begin
            bus.o_e2_valid    <= 1'b0;
            bus.o_e2_br_taken <= 1'b0;
        end else if (bus.i_stage_stall) begin
            // hold
        end else if (stage_ready) begin
            bus.o_e2_valid      <= bus.i_d_valid;
            bus.o_e2_pc         <= bus.i_d_pc;
            bus.o_e2_result     <= result;
            bus.o_e2_mem_addr   <= ea;
            bus.o_e2_store_data <= bus.i_d_rs2_val;
            bus.o_e2_mem_op     <= bus.i_d_mem_op;
            bus.o_e2_mem_size   <= bus.i_d_mem_size;
            bus.o_e2_mem_signed <= bus.i_d_mem_signed;
            bus.o_e2_rd_idx     <= bus.i_d_rd_idx;
            bus.o_e2_rd_we      <= bus.i_d_rd_we;
            bus.o_e2_br_taken   <= bus.i_d_valid & taken;
            bus.o_e2_br_target  <= br_target;
        end else begin
            bus.o_e2_valid    <= 1'b0;
            bus.o_e2_br_taken <= 1'b0;
        end
    end

`ifdef LETC_CORE_E1_DEBUG_EN
    logic [7:0] dbg_cnt;

    // Count valid instructions captured into E2
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dbg_cnt <= 8'h00;
        end else if (~bus.i_stage_flush & stage_ready & bus.i_d_valid) begin
            dbg_cnt <= dbg_cnt + 8'h01;
        end
    end

    assign o_debug = dbg_cnt;
`else
    assign o_debug = 8'h00;
`endif
endmodule

// File: tb/tb_letc_core_stage_e1.sv
// Directed bench for letc_core_stage_e1: a table of ALU/branch vectors plus
// hand-written sequences for reset, TLB back-pressure, stall and flush.
module tb_letc_core_stage_e1;
    logic       clk;
    logic       rst_n;
    logic [7:0] debug;
    int         tests;
    int         fails;
    int         exp_dbg;

    letc_core_stage_e1_if bus ();

    letc_core_stage_e1 dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave),
        .o_debug (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        op1_sel;
        logic        op2_sel;
        logic [3:0]  alu_op;
        logic [1:0]  br_type;
        logic [2:0]  br_cond;
        logic [31:0] exp_result;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic [31:0] exp_addr;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2,
                                logic [31:0] imm, logic o1, logic o2, logic [3:0] alu,
                                logic [1:0] brt, logic [2:0] brc, logic [31:0] res,
                                logic tk, logic [31:0] tgt, logic [31:0] addr);
        vec_t v;
        v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.op1_sel = o1; v.op2_sel = o2; v.alu_op = alu;
        v.br_type = brt; v.br_cond = brc;
        v.exp_result = res; v.exp_taken = tk; v.exp_target = tgt; v.exp_addr = addr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_instr(input logic valid, input logic [31:0] pc, input logic [31:0] rs1,
                             input logic [31:0] rs2, input logic [31:0] imm,
                             input logic o1, input logic o2, input logic [3:0] alu,
                             input logic [1:0] brt, input logic [2:0] brc,
                             input logic [1:0] mem_op, input logic [4:0] rd);
        bus.i_d_valid      = valid;
        bus.i_d_pc         = pc;
        bus.i_d_rs1_val    = rs1;
        bus.i_d_rs2_val    = rs2;
        bus.i_d_imm        = imm;
        bus.i_d_op1_sel    = o1;
        bus.i_d_op2_sel    = o2;
        bus.i_d_alu_op     = alu;
        bus.i_d_br_type    = brt;
        bus.i_d_br_cond    = brc;
        bus.i_d_mem_op     = mem_op;
        bus.i_d_mem_size   = 2'd2;
        bus.i_d_mem_signed = 1'b1;
        bus.i_d_rd_idx     = rd;
        bus.i_d_rd_we      = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dbg_exp(input int n);
`ifdef LETC_CORE_E1_DEBUG_EN
        return 32'(n[7:0]);
`else
        return 32'(n - n);
`endif
    endfunction

    initial begin
        tests   = 0;
        fails   = 0;
        exp_dbg = 0;

        // ALU, branch and jump vectors
        vecs[0]  = mk(32'h10, 32'd5, 32'd7, 32'h0, 0, 0, 4'd0, 2'd0, 3'd0, 32'd12, 0, 32'h0, 32'd5);
        vecs[1]  = mk(32'h10, 32'd3, 32'd5, 32'h0, 0, 0, 4'd1, 2'd0, 3'd0, 32'hFFFFFFFE, 0, 32'h0, 32'd3);
        vecs[2]  = mk(32'h10, 32'h80000000, 32'd4, 32'h0, 0, 0, 4'd7, 2'd0, 3'd0, 32'hF8000000, 0, 32'h0, 32'h80000000);
        vecs[3]  = mk(32'h10, 32'd1, 32'hFFFFFFFF, 32'h0, 0, 0, 4'd4, 2'd0, 3'd0, 32'd1, 0, 32'h0, 32'd1);
        vecs[4]  = mk(32'h10, 32'd1, 32'hFFFFFFFF, 32'h0, 0, 0, 4'd3, 2'd0, 3'd0, 32'd0, 0, 32'h0, 32'd1);
        vecs[5]  = mk(32'h10, 32'd1, 32'h3F, 32'h0, 0, 0, 4'd2, 2'd0, 3'd0, 32'h80000000, 0, 32'h0, 32'd1);
        vecs[6]  = mk(32'h10, 32'h80000000, 32'd4, 32'h0, 0, 0, 4'd6, 2'd0, 3'd0, 32'h08000000, 0, 32'h0, 32'h80000000);
        vecs[7]  = mk(32'h10, 32'hF0F0, 32'hFF00, 32'h0, 0, 0, 4'd5, 2'd0, 3'd0, 32'h0FF0, 0, 32'h0, 32'hF0F0);
        vecs[8]  = mk(32'h10, 32'hF0F0, 32'hFF00, 32'h0, 0, 0, 4'd8, 2'd0, 3'd0, 32'hFFF0, 0, 32'h0, 32'hF0F0);
        vecs[9]  = mk(32'h10, 32'hF0F0, 32'hFF00, 32'h0, 0, 0, 4'd9, 2'd0, 3'd0, 32'hF000, 0, 32'h0, 32'hF0F0);
        vecs[10] = mk(32'h10, 32'h11, 32'h0, 32'h12345000, 0, 1, 4'd10, 2'd0, 3'd0, 32'h12345000, 0, 32'h0, 32'h12345011);
        vecs[11] = mk(32'h10, 32'd2, 32'd3, 32'h0, 0, 0, 4'd15, 2'd0, 3'd0, 32'd5, 0, 32'h0, 32'd2);
        vecs[12] = mk(32'h1000, 32'h0, 32'h0, 32'h20, 1, 1, 4'd0, 2'd0, 3'd0, 32'h1020, 0, 32'h0, 32'h20);
        vecs[13] = mk(32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 0, 0, 4'd0, 2'd1, 3'd4, 32'h0, 1, 32'h120, 32'h1F);
        vecs[14] = mk(32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 0, 0, 4'd0, 2'd1, 3'd6, 32'h0, 0, 32'h0, 32'h1F);
        vecs[15] = mk(32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 0, 0, 4'd0, 2'd1, 3'd5, 32'h0, 0, 32'h0, 32'h1F);
        vecs[16] = mk(32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 0, 0, 4'd0, 2'd1, 3'd7, 32'h0, 1, 32'h120, 32'h1F);
        vecs[17] = mk(32'h100, 32'd7, 32'd7, 32'h20, 0, 0, 4'd0, 2'd1, 3'd0, 32'd14, 1, 32'h120, 32'h27);
        vecs[18] = mk(32'h100, 32'd7, 32'd7, 32'h20, 0, 0, 4'd0, 2'd1, 3'd1, 32'd14, 0, 32'h0, 32'h27);
        vecs[19] = mk(32'h100, 32'd7, 32'd7, 32'h20, 0, 0, 4'd0, 2'd1, 3'd2, 32'd14, 0, 32'h0, 32'h27);
        vecs[20] = mk(32'h200, 32'h0, 32'h0, 32'h40, 0, 0, 4'd0, 2'd2, 3'd0, 32'h204, 1, 32'h240, 32'h40);
        vecs[21] = mk(32'h300, 32'h203, 32'h0, 32'h0, 0, 0, 4'd0, 2'd3, 3'd0, 32'h304, 1, 32'h202, 32'h203);
        vecs[22] = mk(32'h100, 32'd1, 32'd2, 32'hFFFFFFF0, 0, 0, 4'd0, 2'd1, 3'd1, 32'd3, 1, 32'hF0, 32'hFFFFFFF1);

        // Reset with a valid instruction present: registers must stay clear
        rst_n = 1'b0;
        bus.i_stage_flush    = 1'b0;
        bus.i_stage_stall    = 1'b0;
        bus.i_dtlb_req_ready = 1'b1;
        set_instr(1'b1, 32'h200, 32'h0, 32'h0, 32'h40, 0, 0, 4'd0, 2'd2, 3'd0, 2'd0, 5'd3);
        tick();
        tick();
        chk("rst_valid", 32'(bus.o_e2_valid), 32'd0);
        chk("rst_taken", 32'(bus.o_e2_br_taken), 32'd0);
        chk("rst_rd_we", 32'(bus.o_e2_rd_we), 32'd0);
        chk("rst_result", bus.o_e2_result, 32'd0);
        chk("rst_debug", 32'(debug), 32'd0);

        // Idle after release
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_d_valid = 1'b0;
        tick();
        tick();
        chk("idle_valid", 32'(bus.o_e2_valid), 32'd0);
        chk("idle_taken", 32'(bus.o_e2_br_taken), 32'd0);
        chk("idle_debug", 32'(debug), dbg_exp(exp_dbg));

        // Table-driven ALU / branch vectors, one capture per cycle
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            set_instr(1'b1, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                      vecs[i].op1_sel, vecs[i].op2_sel, vecs[i].alu_op,
                      vecs[i].br_type, vecs[i].br_cond, 2'd0, 5'(i));
            tick();
            exp_dbg++;
            chk($sformatf("v%0d_valid", i), 32'(bus.o_e2_valid), 32'd1);
            chk($sformatf("v%0d_result", i), bus.o_e2_result, vecs[i].exp_result);
            chk($sformatf("v%0d_taken", i), 32'(bus.o_e2_br_taken), 32'(vecs[i].exp_taken));
            if (vecs[i].exp_taken)
                chk($sformatf("v%0d_target", i), bus.o_e2_br_target, vecs[i].exp_target);
            chk($sformatf("v%0d_addr", i), bus.o_e2_mem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_sdata", i), bus.o_e2_store_data, vecs[i].rs2);
            chk($sformatf("v%0d_pc", i), bus.o_e2_pc, vecs[i].pc);
            chk($sformatf("v%0d_rd", i), 32'(bus.o_e2_rd_idx), 32'(i));
            chk($sformatf("v%0d_debug", i), 32'(debug), dbg_exp(exp_dbg));
        end

        // Load under DTLB back-pressure: bubble, then capture when ready
        @(negedge clk);
        set_instr(1'b1, 32'h400, 32'h12345000, 32'hCAFEF00D, 32'h10, 0, 1, 4'd0, 2'd0, 3'd0, 2'd1, 5'd9);
        bus.i_dtlb_req_ready = 1'b0;
        #1;
        chk("ld_req_valid", 32'(bus.o_dtlb_req_valid), 32'd1);
        chk("ld_req_vpn", 32'(bus.o_dtlb_req_vpn), 32'h12345);
        chk("ld_ready_lo", 32'(bus.o_stage_ready), 32'd0);
        tick();
        chk("ld_bubble_valid", 32'(bus.o_e2_valid), 32'd0);
        @(negedge clk);
        bus.i_dtlb_req_ready = 1'b1;
        #1;
        chk("ld_ready_hi", 32'(bus.o_stage_ready), 32'd1);
        tick();
        exp_dbg++;
        chk("ld_valid", 32'(bus.o_e2_valid), 32'd1);
        chk("ld_addr", bus.o_e2_mem_addr, 32'h12345010);
        chk("ld_mem_op", 32'(bus.o_e2_mem_op), 32'd1);
        chk("ld_sdata", bus.o_e2_store_data, 32'hCAFEF00D);

        // Invalid JAL + load: no request, no valid, no redirect
        @(negedge clk);
        set_instr(1'b0, 32'h200, 32'h0, 32'h0, 32'h40, 0, 0, 4'd0, 2'd2, 3'd0, 2'd1, 5'd1);
        #1;
        chk("inv_req_valid", 32'(bus.o_dtlb_req_valid), 32'd0);
        tick();
        chk("inv_valid", 32'(bus.o_e2_valid), 32'd0);
        chk("inv_taken", 32'(bus.o_e2_br_taken), 32'd0);

        // Capture ADD, then stall three cycles with a different instruction
        @(negedge clk);
        set_instr(1'b1, 32'h500, 32'd5, 32'd7, 32'h0, 0, 0, 4'd0, 2'd0, 3'd0, 2'd0, 5'd4);
        tick();
        exp_dbg++;
        chk("st_cap_result", bus.o_e2_result, 32'd12);
        @(negedge clk);
        set_instr(1'b1, 32'h600, 32'h1000, 32'h0, 32'h40, 0, 0, 4'd0, 2'd2, 3'd0, 2'd1, 5'd7);
        bus.i_stage_stall = 1'b1;
        #1;
        chk("st_req_valid", 32'(bus.o_dtlb_req_valid), 32'd0);
        chk("st_ready", 32'(bus.o_stage_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("st%0d_valid", c), 32'(bus.o_e2_valid), 32'd1);
            chk($sformatf("st%0d_result", c), bus.o_e2_result, 32'd12);
            chk($sformatf("st%0d_pc", c), bus.o_e2_pc, 32'h500);
            chk($sformatf("st%0d_taken", c), 32'(bus.o_e2_br_taken), 32'd0);
        end

        // Flush together with stall kills the held instruction
        @(negedge clk);
        bus.i_stage_flush = 1'b1;
        #1;
        chk("fl_req_valid", 32'(bus.o_dtlb_req_valid), 32'd0);
        tick();
        chk("fl_valid", 32'(bus.o_e2_valid), 32'd0);
        chk("fl_taken", 32'(bus.o_e2_br_taken), 32'd0);

        // Flush alone with a valid JAL present: no capture, no redirect
        @(negedge clk);
        bus.i_stage_stall = 1'b0;
        tick();
        chk("fl2_valid", 32'(bus.o_e2_valid), 32'd0);
        chk("fl2_taken", 32'(bus.o_e2_br_taken), 32'd0);
        chk("final_debug", 32'(debug), dbg_exp(exp_dbg));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
